// File: rtl/instr_dispatch.sv
// instr_dispatch: captures a 64-bit instruction from the fetch FSM, decodes
// it, launches one execution engine (load / compute / store) with a
// start/done handshake and returns a one-cycle completion pulse.
// Keeps sticky error flags and a wrapping completed-instruction counter.
// Optional feature macro: DISPATCH_TIMEOUT_EN (adds WAIT timeout and the
// timeout_err output port).
module instr_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instruction_enable,
   input  logic [63:0]      ctr,
   output logic             instr_exe_state,
   output logic             busy,
   output logic             ld_start,
   input  logic             ld_done,
   output logic             cmp_start,
   input  logic             cmp_done,
   output logic             st_start,
   input  logic             st_done,
   output logic [19:0]      ext_addr,
   output logic [11:0]      buf_addr,
   output logic [15:0]      xfer_len,
   output logic [11:0]      op_param,
   output logic             illegal_op,
   output logic             overrun,
   input  logic             err_clr,
`ifdef DISPATCH_TIMEOUT_EN
   output logic             timeout_err,
`endif
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_COMP  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;

   state_t      state_q;
   state_t      state_d;
   logic [63:0] ir_q;
   logic [3:0]  opcode;
   logic        is_engine;
   logic        sel_done;
   logic        timeout_hit;
   logic        illegal_set;
   logic        overrun_set;

   assign opcode    = ir_q[63:60];
   assign is_engine = (opcode == OP_LOAD) || (opcode == OP_COMP) || (opcode == OP_STORE);

   // Field outputs come straight from the instruction register, which only
   // reloads on an accepted instruction, so they hold from DECODE onward.
   assign ext_addr = ir_q[59:40];
   assign buf_addr = ir_q[39:28];
   assign xfer_len = ir_q[27:12];
   assign op_param = ir_q[11:0];

   assign illegal_set = (state_q == S_DECODE) && !is_engine && (opcode != OP_NOP);
   assign overrun_set = instruction_enable && (state_q != S_IDLE);

   // Only the engine selected by the current opcode may complete the WAIT.
   always_comb begin
      sel_done = 1'b0;
      case (opcode)
         OP_LOAD:  sel_done = ld_done;
         OP_COMP:  sel_done = cmp_done;
         OP_STORE: sel_done = st_done;
         default:  sel_done = 1'b0;
      endcase
   end

`ifdef DISPATCH_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WAIT_W-1:0] wait_cnt_q;

   // Counter value c means c+1 WAIT cycles elapsed at the end of this cycle,
   // so matching TIMEOUT_CYCLES-1 leaves WAIT after exactly TIMEOUT_CYCLES.
   assign timeout_hit = (state_q == S_WAIT) && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   // WAIT cycle counter: cleared while issuing, counts every WAIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt_q <= '0;
      else if (state_q == S_ISSUE)
         wait_cnt_q <= '0;
      else if (state_q == S_WAIT)
         wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
   end

   // Sticky timeout flag; a done in the expiry cycle suppresses it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timeout_err <= 1'b0;
      else if (timeout_hit && !sel_done)
         timeout_err <= 1'b1;
      else if (err_clr)
         timeout_err <= 1'b0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (instruction_enable) state_d = S_DECODE;
         S_DECODE: state_d = is_engine ? S_ISSUE : S_DONE;
         S_ISSUE:  state_d = S_WAIT;
         S_WAIT:   if (sel_done || timeout_hit) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy            = (state_q != S_IDLE);
      instr_exe_state = (state_q == S_DONE);
      ld_start        = (state_q == S_ISSUE) && (opcode == OP_LOAD);
      cmp_start       = (state_q == S_ISSUE) && (opcode == OP_COMP);
      st_start        = (state_q == S_ISSUE) && (opcode == OP_STORE);
   end

   // Instruction register: loads only on an accepted strobe in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ir_q <= '0;
      else if ((state_q == S_IDLE) && instruction_enable)
         ir_q <= ctr;
   end

   // Sticky error flags; a set in the same cycle as err_clr wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_op <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (illegal_set)
            illegal_op <= 1'b1;
         else if (err_clr)
            illegal_op <= 1'b0;
         if (overrun_set)
            overrun <= 1'b1;
         else if (err_clr)
            overrun <= 1'b0;
      end
   end

   // Completed-instruction counter, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         instr_count <= '0;
      else if (state_q == S_DONE)
         instr_count <= instr_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_instr_dispatch.sv
// Testbench for instr_dispatch: directed scenarios plus randomized
// instruction streams checked every cycle against a transaction-level
// reference model (expected completion cycle per instruction, sticky flags,
// counter and field values). Optional macro: DISPATCH_TIMEOUT_EN.
module tb_instr_dispatch;

   localparam int unsigned TO    = 8;
   localparam int unsigned CNT_W = 16;
`ifdef DISPATCH_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             instruction_enable = 1'b0;
   logic [63:0]      ctr = '0;
   logic             instr_exe_state;
   logic             busy;
   logic             ld_start, cmp_start, st_start;
   logic             ld_done = 1'b0, cmp_done = 1'b0, st_done = 1'b0;
   logic [19:0]      ext_addr;
   logic [11:0]      buf_addr;
   logic [15:0]      xfer_len;
   logic [11:0]      op_param;
   logic             illegal_op, overrun;
   logic             err_clr = 1'b0;
   logic [CNT_W-1:0] instr_count;
   logic             to_flag;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [59:0]      m_fields = '0;
   logic             m_ill = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
   logic [CNT_W-1:0] m_cnt = '0;

   always #5 clk = ~clk;

   instr_dispatch #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .instruction_enable(instruction_enable), .ctr(ctr),
      .instr_exe_state(instr_exe_state), .busy(busy),
      .ld_start(ld_start), .ld_done(ld_done),
      .cmp_start(cmp_start), .cmp_done(cmp_done),
      .st_start(st_start), .st_done(st_done),
      .ext_addr(ext_addr), .buf_addr(buf_addr),
      .xfer_len(xfer_len), .op_param(op_param),
      .illegal_op(illegal_op), .overrun(overrun), .err_clr(err_clr),
`ifdef DISPATCH_TIMEOUT_EN
      .timeout_err(to_flag),
`endif
      .instr_count(instr_count)
   );

`ifndef DISPATCH_TIMEOUT_EN
   assign to_flag = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input logic e_busy, input logic e_exe, input logic [2:0] e_start);
      check("busy", 64'(busy), 64'(e_busy));
      check("exe", 64'(instr_exe_state), 64'(e_exe));
      check("start", 64'({st_start, cmp_start, ld_start}), 64'(e_start));
      check("flags", 64'({to_flag, overrun, illegal_op}), 64'({m_to, m_ovr, m_ill}));
      check("count", 64'(instr_count), 64'(m_cnt));
      check("fields", 64'({ext_addr, buf_addr, xfer_len, op_param}), 64'(m_fields));
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
   task automatic cycle(input logic en, input logic [63:0] word, input logic [2:0] dn,
                        input logic clr, input logic e_busy, input logic e_exe,
                        input logic [2:0] e_start, input logic set_ill, input logic set_to,
                        input logic do_count, input logic capture);
      logic set_ovr;
      instruction_enable = en;
      ctr      = word;
      ld_done  = dn[0];
      cmp_done = dn[1];
      st_done  = dn[2];
      err_clr  = clr;
      @(negedge clk);
      check_all(e_busy, e_exe, e_start);
      @(posedge clk);
      #1;
      set_ovr = en && e_busy;
      m_ill = set_ill | (m_ill & ~clr);
      m_ovr = set_ovr | (m_ovr & ~clr);
      m_to  = set_to  | (m_to  & ~clr);
      if (do_count) m_cnt = m_cnt + 1'b1;
      if (capture)  m_fields = word[59:0];
   endtask

   // Idle cycles between instructions.
   task automatic gap(input int unsigned n, input logic noisy, input logic clr_first);
      for (int unsigned i = 0; i < n; i++) begin
         logic [2:0] dn;
         logic       clr;
         dn  = noisy ? 3'($urandom_range(0, 7)) : 3'b000;
         clr = (i == 0 && clr_first) || (noisy && $urandom_range(0, 4) == 0);
         cycle(1'b0, {$urandom, $urandom}, dn, clr, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // One instruction: expected completion is 2 cycles after the strobe for
   // NOP/illegal, otherwise 3 cycles after the strobe plus the engine delay d
   // (d = cycles from start to done), capped by the timeout when enabled.
   task automatic run_instr(input logic [63:0] word, input int unsigned d, input logic noisy,
                            input int unsigned ovr_at, input logic others);
      logic [3:0]  op;
      logic        eng;
      logic [2:0]  sel;
      logic        timed_out;
      int unsigned exe_c;
      op        = word[63:60];
      eng       = (op >= 4'd1) && (op <= 4'd3);
      sel       = eng ? (3'b001 << (op - 4'd1)) : 3'b000;
      timed_out = eng && TO_EN && (d > TO);
      exe_c     = !eng ? 2 : (timed_out ? 3 + TO : 3 + d);
      for (int unsigned c = 0; c <= exe_c; c++) begin
         logic        en;
         logic [63:0] w;
         logic [2:0]  dn;
         logic        clr;
         en = (c == 0) || (c >= 1 && ((noisy && $urandom_range(0, 5) == 0) || c == ovr_at));
         w  = (c == 0) ? word : {$urandom, $urandom};
         dn = others ? (3'($urandom_range(0, 7)) & ~sel) : 3'b000;
         if (eng && c == 2 + d) dn = dn | sel;
         if (eng && noisy && c <= 2 && $urandom_range(0, 3) == 0) dn = dn | sel;
         clr = noisy && ($urandom_range(0, 4) == 0);
         cycle(en, w, dn, clr, (c >= 1), (c == exe_c),
               (eng && c == 2) ? sel : 3'b000,
               (c == 1) && !eng && (op != 4'd0),
               timed_out && (c == exe_c - 1),
               (c == exe_c), (c == 0));
      end
   endtask

   // Asynchronous reset between clock edges while a COMP sits in WAIT.
   task automatic mid_wait_reset();
      logic [63:0] w;
      w = {4'h2, 60'hFEDCBA987654321};
      for (int unsigned c = 0; c <= 4; c++)
         cycle((c == 0), (c == 0) ? w : 64'h0, 3'b000, 1'b0, (c >= 1), 1'b0,
               (c == 2) ? 3'b010 : 3'b000, 1'b0, 1'b0, 1'b0, (c == 0));
      instruction_enable = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      m_ill = 1'b0; m_ovr = 1'b0; m_to = 1'b0; m_cnt = '0; m_fields = '0;
      check_all(1'b0, 1'b0, 3'b000);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      check_all(1'b0, 1'b0, 3'b000);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      gap(1, 1'b0, 1'b0);

      // NOP: completes 2 cycles after the strobe, no start pulses
      run_instr(64'h0, 1, 1'b0, 0, 1'b0);
      gap(1, 1'b0, 1'b0);
      // LOAD with done 8 cycles after start, foreign dones ignored
      run_instr({4'h1, 20'hABCD5, 12'hA50, 16'h1000, 12'h07F}, 8, 1'b0, 0, 1'b1);
      // Illegal opcode, then err_clr
      run_instr({4'h7, 60'h0123456789ABCDE}, 1, 1'b0, 0, 1'b0);
      gap(2, 1'b0, 1'b1);
      // COMP with a second strobe during WAIT
      run_instr({4'h2, 60'h111122223333444}, 6, 1'b0, 4, 1'b0);
      gap(1, 1'b0, 1'b1);
      // STORE: done right at the timeout boundary, then no done at all
      run_instr({4'h3, 60'h0A0B0C0D0E0F101}, TO, 1'b0, 0, 1'b1);
      run_instr({4'h3, 60'h5555AAAA5555AAA}, TO + 6, 1'b0, 0, 1'b1);
      gap(1, 1'b0, 1'b1);

      for (int n = 0; n < 200; n++) begin
         logic [63:0] w;
         int unsigned k;
         w = {$urandom, $urandom};
         k = $urandom_range(0, 5);
         w[63:60] = (k <= 3) ? 4'(k) : 4'($urandom_range(4, 15));
         run_instr(w, $urandom_range(1, 12), 1'b1, 0, 1'b1);
         gap($urandom_range(0, 2), 1'b1, 1'b0);
      end

      mid_wait_reset();
      run_instr({4'h1, 60'h0FEDCBA98765432}, 3, 1'b0, 0, 1'b0);
      gap(1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
- Sits directly downstream of the accelerator top-level fetch FSM.
- Captures each 64-bit instruction word on the `ctr` bus when `instruction_enable` pulses, decodes it, and launches exactly one execution engine (load, compute or store) with a start/done handshake.
- Returns a one-cycle `instr_exe_state` pulse so the fetch FSM advances to the next instruction.
- Also keeps sticky error flags and a completed-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles in WAIT before timeout. Used only with the optional feature.
- CNT_W, 16: width of the `instr_count` counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- instruction_enable  in  1  one-cycle strobe; `ctr` is valid in the same cycle
- ctr  in  64  instruction word
- instr_exe_state  out  1  one-cycle pulse: instruction complete
- busy  out  1  high in every state except IDLE
- ld_start  out  1  load engine start pulse
- ld_done  in  1  load engine done pulse
- cmp_start  out  1  compute engine start pulse
- cmp_done  in  1  compute engine done pulse
- st_start  out  1  store engine start pulse
- st_done  in  1  store engine done pulse
- ext_addr  out  20  external memory address field
- buf_addr  out  12  on-chip buffer address field
- xfer_len  out  16  transfer length / loop count field
- op_param  out  12  opcode-specific parameter field
- illegal_op  out  1  sticky: undefined opcode received
- overrun  out  1  sticky: `instruction_enable` seen while busy
- err_clr  in  1  synchronous clear of all sticky flags
- instr_count  out  CNT_W  instructions completed, wraps

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE.

Instruction format:
- [63:60] opcode: 0x0 NOP, 0x1 LOAD, 0x2 COMP, 0x3 STORE; all other values illegal.
- [59:40] `ext_addr`, [39:28] `buf_addr`, [27:12] `xfer_len`, [11:0] `op_param`.

State machine (IDLE, DECODE, ISSUE, WAIT, DONE):
- IDLE: on `instruction_enable`=1, register `ctr` into the instruction register and go to DECODE.
- DECODE (one cycle):
  - Drive the field outputs from the instruction register.
  - Select the target engine.
  - NOP goes to DONE.
  - An illegal opcode sets `illegal_op` and goes to DONE (treated as NOP).
  - LOAD, COMP and STORE go to ISSUE.
- ISSUE (one cycle): assert exactly one of `ld_start` / `cmp_start` / `st_start`, then go to WAIT.
- WAIT:
  - Sample only the selected engine's done signal; done signals from other engines are ignored.
  - Done is not sampled in the ISSUE cycle, so the earliest accepted done is the cycle after start.
  - On done, go to DONE.
- DONE (one cycle): `instr_exe_state`=1, `instr_count` += 1 (wraps to 0 at all-ones), go to IDLE.

Timing and holding rules:
- Field outputs hold stable from DECODE until the next DECODE.
- Minimum latency from `instruction_enable` to `instr_exe_state`:
  - NOP: 3 cycles (IDLE capture, DECODE, DONE).
  - Engine instruction: 4 + engine latency.
- `busy` = (state != IDLE).

Boundary conditions:
- `instruction_enable` while not IDLE: the word is ignored, `overrun` is set, and the in-flight instruction is unaffected.
- `err_clr` and a flag-setting event in the same cycle: the set wins.
- A done strobe in IDLE, DECODE or DONE is ignored.
- `rst` mid-WAIT: immediate return to IDLE with all outputs 0. Engines are reset by the same `rst`.

Optional Feature:
- Macro: `DISPATCH_TIMEOUT_EN`.
- When defined:
  - Adds output port `timeout_err` (1 bit, sticky, cleared by `err_clr`).
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES without done: set `timeout_err`, go to DONE, and still pulse `instr_exe_state` so fetch does not hang.
  - A done arriving in that same cycle wins: no error is flagged.
- When not defined:
  - No port and no counter.
  - WAIT holds indefinitely until done.

Test Plan:
- Reset, then `ctr`=0x0000_0000_0000_0000 with `instruction_enable` pulse at T: `instr_exe_state` at T+2, `instr_count`=1, no start pulses.
- `ctr`=0x1ABCD_5A5_0100_07F placed as opcode 1, `ext_addr`=0xABCD5, `buf_addr`=0xA50, `xfer_len`=0x1000, `op_param`=0x07F:
  - `ld_start` pulses at T+2 with the field outputs already stable.
  - `ld_done` at T+10 produces `instr_exe_state` at T+11.
  - `cmp_done` or `st_done` pulsed during WAIT is ignored.
- Opcode 0x7: `illegal_op`=1, `instr_exe_state` at T+2, no start pulse. `err_clr` clears the flag the following cycle.
- Second `instruction_enable` during WAIT of a COMP: `overrun`=1, exactly one `cmp_start`, and `instr_count` increments by 1 only.
- With `DISPATCH_TIMEOUT_EN` and TIMEOUT_CYCLES=8: STORE with no `st_done` gives `timeout_err`=1 and `instr_exe_state` 8 cycles after WAIT entry.
- Async `rst` asserted mid-WAIT (between clock edges): all outputs 0 immediately. The next instruction completes normally and `instr_count` restarts from 0.
